// File: rtl/divider_arbiter_pkg.sv
// Shared types and default sizes for the divider arbiter.
// Build option: DIVIDER_ARBITER_PRIO_EN selects fixed-priority arbitration.
package divider_arbiter_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_LENW  = 8;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_DONE
    } state_t;

endpackage

// File: rtl/divider_arbiter_if.sv
// Requester-side bundle of the divider arbiter.
// master drives requests, slave (the arbiter) drives grant and clock.
interface divider_arbiter_if
    import divider_arbiter_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int WIDTH = DEF_WIDTH,
    parameter int LENW  = DEF_LENW
);

    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] scale;
    logic [NREQ*LENW-1:0]  len;
    logic [NREQ-1:0]       gnt;
    logic                  busy;
    logic                  clk_out;
    logic                  tick;
    logic                  done;

    modport master (
        output req, scale, len,
        input  gnt, busy, clk_out, tick, done
    );

    modport slave (
        input  req, scale, len,
        output gnt, busy, clk_out, tick, done
    );

endinterface

// File: rtl/divider_arbiter_rr_pick.sv
// Combinational round-robin winner selection.
// Search starts one past 'last'; last = NREQ-1 gives lowest-index priority.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last,
    output logic [NREQ-1:0] onehot,
    output logic [IW-1:0]   idx
);

    logic found;
    int   j;

    // first set request after 'last', wrapping around
    always_comb begin
        onehot = '0;
        idx    = '0;
        found  = 1'b0;
        j      = 0;
        for (int k = 1; k <= NREQ; k++) begin
            j = (int'(last) + k) % NREQ;
            if (!found && req[j]) begin
                found     = 1'b1;
                onehot[j] = 1'b1;
                idx       = IW'(j);
            end
        end
    end

endmodule

// File: rtl/divider_arbiter.sv
// Shares one programmable clock divider among NREQ requesters.
// Build option: DIVIDER_ARBITER_PRIO_EN -> fixed priority, no last-index reg.
module divider_arbiter
    import divider_arbiter_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int WIDTH = DEF_WIDTH,
    parameter int LENW  = DEF_LENW
) (
    input  logic CLK,
    input  logic rst_n,
    divider_arbiter_if.slave bus
);

    localparam int IW = $clog2(NREQ);

    state_t            state;
    logic [IW-1:0]     idx_q;
    logic [IW-1:0]     last;
    logic [IW-1:0]     pick_idx;
    logic [NREQ-1:0]   pick_oh;
    logic [WIDTH-1:0]  scale_q;
    logic [WIDTH-1:0]  cnt;
    logic [WIDTH-1:0]  scale_w;
    logic [LENW-1:0]   len_w;
    logic [LENW-1:0]   remaining;
    logic [WIDTH:0]    cnt_nx;
    logic              req_live;
    logic              ending;

    assign scale_w  = bus.scale[int'(idx_q)*WIDTH +: WIDTH];
    assign len_w    = bus.len[int'(idx_q)*LENW +: LENW];
    assign req_live = bus.req[idx_q];
    assign cnt_nx   = {1'b0, cnt} + (WIDTH+1)'(1);
    assign bus.busy = (state != S_IDLE);

    // a burst ends normally through DONE or by abort in LOAD/RUN
    assign ending = (state == S_DONE) ||
                    (((state == S_LOAD) || (state == S_RUN)) && !req_live);

    rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_pick (
        .req    (bus.req),
        .last   (last),
        .onehot (pick_oh),
        .idx    (pick_idx)
    );

`ifdef DIVIDER_ARBITER_PRIO_EN
    assign last = IW'(NREQ - 1);
`else
    // remember the requester of the burst that just finished
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n)
            last <= IW'(NREQ - 1);
        else if (ending)
            last <= idx_q;
    end
`endif

    // burst sequencer with registered outputs
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            idx_q       <= '0;
            scale_q     <= '0;
            cnt         <= '0;
            remaining   <= '0;
            bus.gnt     <= '0;
            bus.clk_out <= 1'b0;
            bus.tick    <= 1'b0;
            bus.done    <= 1'b0;
        end else begin
            bus.tick <= 1'b0;
            bus.done <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (|bus.req) begin
                        idx_q   <= pick_idx;
                        bus.gnt <= pick_oh;
                        state   <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (!req_live) begin
                        bus.gnt     <= '0;
                        bus.clk_out <= 1'b0;
                        state       <= S_IDLE;
                    end else begin
                        scale_q   <= (scale_w == '0) ? WIDTH'(1) : scale_w;
                        remaining <= len_w;
                        cnt       <= '0;
                        state     <= (len_w == '0) ? S_DONE : S_RUN;
                    end
                end
                S_RUN: begin
                    if (!req_live) begin
                        bus.gnt     <= '0;
                        bus.clk_out <= 1'b0;
                        state       <= S_IDLE;
                    end else if (cnt_nx >= {1'b0, scale_q}) begin
                        bus.clk_out <= ~bus.clk_out;
                        bus.tick    <= 1'b1;
                        cnt         <= '0;
                        remaining   <= remaining - 1'b1;
                        if (remaining == LENW'(1))
                            state <= S_DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    bus.done    <= 1'b1;
                    bus.clk_out <= 1'b0;
                    bus.gnt     <= '0;
                    state       <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
